ycr1_cache_line_wb_mst: RTL and testbench

//  Cache-side Wishbone burst master. Turns one line-refill (read) or line-writeback (write) request

---
 rtl/ycr1_cache_line_wb_mst.sv | 178 +++++++++++++++++
 tb/tb_ycr1_cache_line_wb_mst.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_cache_line_wb_mst.sv
// Cache-side Wishbone burst master: one line refill or writeback per request,
// issued as a single fixed-length burst with per-beat ack and abort handling.
module ycr1_cache_line_wb_mst #(
  parameter int unsigned YCR1_WB_WIDTH = 32,
  parameter int unsigned LINE_WORDS    = 8,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // cache controller request
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [YCR1_WB_WIDTH-1:0]       req_addr,
  // line buffer
  output logic [$clog2(LINE_WORDS)-1:0]  lb_rd_idx,
  input  logic [YCR1_WB_WIDTH-1:0]       lb_rd_data,
  output logic                           lb_wr_en,
  output logic [$clog2(LINE_WORDS)-1:0]  lb_wr_idx,
  output logic [YCR1_WB_WIDTH-1:0]       lb_wr_data,
  output logic                           done,
  output logic                           done_err,
  // Wishbone master
  output logic                           wbd_stb_o,
  output logic [YCR1_WB_WIDTH-1:0]       wbd_adr_o,
  output logic                           wbd_we_o,
  output logic [YCR1_WB_WIDTH-1:0]       wbd_dat_o,
  output logic [3:0]                     wbd_sel_o,
  output logic [9:0]                     wbd_bl_o,
  input  logic [YCR1_WB_WIDTH-1:0]       wbd_dat_i,
  input  logic                           wbd_ack_i,
  input  logic                           wbd_lack_i,
  input  logic                           wbd_err_i
);

  localparam int unsigned IDXW     = $clog2(LINE_WORDS);
  localparam int unsigned TMOW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [IDXW-1:0]          BEAT_LAST = IDXW'(LINE_WORDS - 1);
  localparam logic [TMOW-1:0]          TMO_MAX   = '1;
  localparam logic [YCR1_WB_WIDTH-1:0] ADR_MASK  = ~(YCR1_WB_WIDTH'(LINE_WORDS * 4 - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_e;

  state_e                   state_q, state_d;
  logic [IDXW-1:0]          beat_q, beat_d;
  logic [TMOW-1:0]          tmo_q, tmo_d;
  logic [YCR1_WB_WIDTH-1:0] adr_q, adr_d;
  logic                     we_q, we_d;
  logic [3:0]               sel_q, sel_d;
  logic [9:0]               bl_q, bl_d;
  logic                     stb_q, stb_d;
  logic                     ready_q, ready_d;
  logic                     wr_en_q, wr_en_d;
  logic [IDXW-1:0]          wr_idx_q, wr_idx_d;
  logic [YCR1_WB_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     done_err_q, done_err_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    bl_d       = bl_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BURST;
          adr_d   = req_addr & ADR_MASK;
          we_d    = req_we;
          sel_d   = 4'hF;
          bl_d    = 10'(LINE_WORDS);
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_BURST: begin
        if (wbd_err_i) begin
          // error wins over a coincident ack; that beat is dropped
          state_d    = ST_GAP;
          done_d     = 1'b1;
          done_err_d = 1'b1;
        end else if (wbd_ack_i) begin
          tmo_d = '0;
          if (!we_q) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = beat_q;
            wr_data_d = wbd_dat_i;
          end
          if (beat_q == BEAT_LAST) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end else if (wbd_lack_i) begin
            state_d    = ST_GAP;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            beat_d = beat_q + IDXW'(1);
          end
        end else if ((TIMEOUT_CYC != 0) && (tmo_q == TMOW'(TMO_LAST))) begin
          state_d    = ST_GAP;
          done_d     = 1'b1;
          done_err_d = 1'b1;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMOW'(1);
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    stb_d   = (state_d == ST_BURST);
    ready_d = (state_d == ST_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      tmo_q      <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      bl_q       <= '0;
      stb_q      <= 1'b0;
      ready_q    <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      bl_q       <= bl_d;
      stb_q      <= stb_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  assign req_ready  = ready_q;
  assign lb_rd_idx  = beat_q;
  assign lb_wr_en   = wr_en_q;
  assign lb_wr_idx  = wr_idx_q;
  assign lb_wr_data = wr_data_q;
  assign done       = done_q;
  assign done_err   = done_err_q;
  assign wbd_stb_o  = stb_q;
  assign wbd_adr_o  = adr_q;
  assign wbd_we_o   = we_q;
  assign wbd_sel_o  = sel_q;
  assign wbd_bl_o   = bl_q;
  // writeback word follows the beat counter through the line buffer read port
  assign wbd_dat_o  = lb_rd_data;

endmodule

// File: tb/tb_ycr1_cache_line_wb_mst.sv
// Scoreboard bench for the cache-line Wishbone burst master.
module tb_ycr1_cache_line_wb_mst;

  localparam int unsigned LW  = 8;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [2:0]  lb_rd_idx, lb_wr_idx;
  logic [31:0] lb_rd_data, lb_wr_data;
  logic        lb_wr_en, done, done_err;
  logic        wbd_stb_o, wbd_we_o;
  logic [31:0] wbd_adr_o, wbd_dat_o, wbd_dat_i;
  logic [3:0]  wbd_sel_o;
  logic [9:0]  wbd_bl_o;
  logic        wbd_ack_i, wbd_lack_i, wbd_err_i;

  logic [31:0] lb_line [LW];
  assign lb_rd_data = lb_line[lb_rd_idx];

  always #5 clk = ~clk;

  ycr1_cache_line_wb_mst #(.YCR1_WB_WIDTH(32), .LINE_WORDS(LW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .lb_rd_idx(lb_rd_idx), .lb_rd_data(lb_rd_data),
    .lb_wr_en(lb_wr_en), .lb_wr_idx(lb_wr_idx), .lb_wr_data(lb_wr_data),
    .done(done), .done_err(done_err),
    .wbd_stb_o(wbd_stb_o), .wbd_adr_o(wbd_adr_o), .wbd_we_o(wbd_we_o), .wbd_dat_o(wbd_dat_o),
    .wbd_sel_o(wbd_sel_o), .wbd_bl_o(wbd_bl_o), .wbd_dat_i(wbd_dat_i),
    .wbd_ack_i(wbd_ack_i), .wbd_lack_i(wbd_lack_i), .wbd_err_i(wbd_err_i)
  );

  typedef struct { logic [2:0] idx; logic [31:0] data; } wr_t;
  typedef struct { logic err; int lat; } done_t;
  typedef struct { logic [31:0] adr; logic we; int gap; } burst_t;

  wr_t    exp_wr[$];
  done_t  exp_done[$];
  burst_t exp_burst[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Slave model state
  int          smode = 0;   // 0 ack always, 1 random stalls, 2 never ack, 3 err at err_beat
  int          err_beat = 0;
  int          sbeat = 0;
  int          stall = 0;
  logic        last_ack = 1'b0, last_stb = 1'b0, last_err = 1'b0;
  logic [31:0] last_dat = '0;
  logic [31:0] wdata [logic [31:0]];
  int          wcnt  [logic [31:0]];

  // Wishbone slave: retire the previous beat, then drive the next response
  initial begin
    logic        ack, err;
    logic [31:0] a;
    wbd_ack_i = 1'b0; wbd_lack_i = 1'b0; wbd_err_i = 1'b0; wbd_dat_i = '0;
    forever begin
      @(negedge clk);
      if (last_ack && last_stb && !last_err) begin
        if (wbd_we_o) begin
          a = wbd_adr_o + 32'(4 * sbeat);
          wdata[a] = last_dat;
          wcnt[a]  = wcnt.exists(a) ? wcnt[a] + 1 : 1;
        end
        sbeat++;
      end
      if (!wbd_stb_o) sbeat = 0;
      ack = 1'b0;
      err = 1'b0;
      if (wbd_stb_o && rst_n) begin
        case (smode)
          0: ack = 1'b1;
          1: if (stall >= 3 || $urandom_range(0, 3) != 0) begin ack = 1'b1; stall = 0; end
             else stall++;
          3: begin ack = 1'b1; err = (sbeat == err_beat); end
          default: ack = 1'b0;
        endcase
      end
      wbd_ack_i  = ack;
      wbd_err_i  = err;
      wbd_lack_i = ack && (sbeat == int'(wbd_bl_o) - 1);
      wbd_dat_i  = ack ? memf(wbd_adr_o + 32'(4 * sbeat)) : 32'h0;
      last_ack = ack;
      last_stb = wbd_stb_o;
      last_err = err;
      last_dat = wbd_dat_o;
    end
  end

  // Monitor: compare every DUT event against the scoreboard queues
  initial begin
    logic   prev_stb = 1'b0;
    int     since_rise = 0;
    int     low_cnt = 1000;
    wr_t    w;
    done_t  d;
    burst_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stb = 1'b0;
        low_cnt  = 1000;
      end else begin
        if (wbd_stb_o && !prev_stb) begin
          if (exp_burst.size() == 0) chk("unexpected_burst", 64'(wbd_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            b = exp_burst.pop_front();
            chk("burst_adr", 64'(wbd_adr_o), 64'(b.adr));
            chk("burst_we",  64'(wbd_we_o),  64'(b.we));
            chk("burst_sel", 64'(wbd_sel_o), 64'h0F);
            chk("burst_bl",  64'(wbd_bl_o),  64'(LW));
            if (b.gap >= 0) chk("burst_gap", 64'(low_cnt), 64'(b.gap));
          end
          since_rise = 0;
          low_cnt    = 0;
        end else begin
          since_rise++;
          if (!wbd_stb_o) low_cnt++;
        end
        if (lb_wr_en) begin
          if (exp_wr.size() == 0) chk("unexpected_lb_wr", 64'(lb_wr_idx), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            w = exp_wr.pop_front();
            chk("lb_wr_idx",  64'(lb_wr_idx),  64'(w.idx));
            chk("lb_wr_data", 64'(lb_wr_data), 64'(w.data));
          end
        end
        if (done) begin
          if (exp_done.size() == 0) chk("unexpected_done", 64'(done_err), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            d = exp_done.pop_front();
            chk("done_err",     64'(done_err),  64'(d.err));
            chk("done_stb_low", 64'(wbd_stb_o), 64'h0);
            if (d.lat >= 0) chk("done_latency", 64'(since_rise), 64'(d.lat));
          end
        end
        prev_stb = wbd_stb_o;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'h1);
    chk({tag, "_wb"}, {wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_sel_o, wbd_bl_o}, 64'h0);
    chk({tag, "_lb"}, {lb_wr_en, done, done_err, lb_wr_idx, lb_rd_idx, lb_wr_data}, 64'h0);
  endtask

  // Present a request at a negedge and wait for its acceptance
  task automatic send(input logic we, input logic [31:0] addr, input bit hold);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_accept_timeout", 64'(n), 64'h0);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_done.size() != 0 || exp_wr.size() != 0) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", 64'(exp_done.size()), 64'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_refill(input logic [31:0] base, input int nwords);
    for (int i = 0; i < nwords; i++) exp_wr.push_back('{3'(i), memf(base + 32'(4 * i))});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    for (int i = 0; i < LW; i++) lb_line[i] = '0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Refill with ack every cycle; unaligned address gets masked
    smode = 0;
    exp_burst.push_back('{32'h1000_0020, 1'b0, -1});
    push_refill(32'h1000_0020, LW);
    exp_done.push_back('{1'b0, 8});
    send(1'b0, 32'h1000_0024, 1'b0);
    wait_drain();

    // Writeback with random stalls
    smode = 1;
    for (int i = 0; i < LW; i++) lb_line[i] = 32'hA0 + 32'(i);
    exp_burst.push_back('{32'h2000_0000, 1'b1, -1});
    exp_done.push_back('{1'b0, -1});
    send(1'b1, 32'h2000_0000, 1'b0);
    wait_drain();
    for (int i = 0; i < LW; i++) begin
      logic [31:0] a;
      a = 32'h2000_0000 + 32'(4 * i);
      chk("wb_mem_data",  wdata.exists(a) ? 64'(wdata[a]) : 64'hDEAD, 64'(32'hA0 + 32'(i)));
      chk("wb_mem_count", wcnt.exists(a) ? 64'(wcnt[a]) : 64'h0, 64'h1);
    end

    // Bus error together with ack on beat 3
    smode = 3; err_beat = 3;
    exp_burst.push_back('{32'h1000_0100, 1'b0, -1});
    push_refill(32'h1000_0100, 3);
    exp_done.push_back('{1'b1, 4});
    send(1'b0, 32'h1000_0100, 1'b0);
    wait_drain();

    // Slave never acks: timeout abort
    smode = 2;
    exp_burst.push_back('{32'h1000_0200, 1'b0, -1});
    exp_done.push_back('{1'b1, 16});
    send(1'b0, 32'h1000_0200, 1'b0);
    wait_drain();

    // Back-to-back requests, valid held between them
    smode = 0;
    exp_burst.push_back('{32'h1000_0300, 1'b0, -1});
    exp_burst.push_back('{32'h1000_0340, 1'b0, 2});
    push_refill(32'h1000_0300, LW);
    push_refill(32'h1000_0340, LW);
    exp_done.push_back('{1'b0, 8});
    exp_done.push_back('{1'b0, 8});
    send(1'b0, 32'h1000_0300, 1'b1);
    send(1'b0, 32'h1000_0347, 1'b0);
    wait_drain();

    // Reset during beat 4 of a writeback
    smode = 0;
    for (int i = 0; i < LW; i++) lb_line[i] = 32'hB0 + 32'(i);
    exp_burst.push_back('{32'h3000_0000, 1'b1, -1});
    send(1'b1, 32'h3000_0000, 1'b0);
    n = 0;
    while (lb_rd_idx != 3'd4 && n < 50) begin @(negedge clk); n++; end
    chk("reach_beat4", 64'(lb_rd_idx), 64'h4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    exp_burst.push_back('{32'h4000_0040, 1'b0, -1});
    push_refill(32'h4000_0040, LW);
    exp_done.push_back('{1'b0, 8});
    send(1'b0, 32'h4000_0040, 1'b0);
    wait_drain();

    chk("leftover_expectations", 64'(exp_wr.size() + exp_done.size() + exp_burst.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
